// File: rtl/mem_responder.sv
// Word-organised memory responder with single and burst (4/8/16 word) read/write access.
// Define MEM_BURST_WRAP_EN for critical-word-first wrapping bursts; default is linear increment.
module mem_responder #(
  parameter logic [31:0] base_addr    = 32'h80020000,
  parameter int unsigned memory_depth = 1048576
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] address,
  input  logic [31:0] data_in,
  input  logic [1:0]  access_size,
  input  logic        rw,
  input  logic        enable,
  output logic        busy,
  output logic [31:0] data_out,
  output logic        addr_err
);

  localparam int unsigned WORDS = memory_depth / 4;
  localparam int          IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic {IDLE, BURST} state_t;

  state_t      state;
  logic [31:0] start_q;
  logic [1:0]  size_q;
  logic        rw_q;
  logic [3:0]  cnt;
  logic [3:0]  k_q;

  logic [31:0] mem [WORDS];

  logic             beat_go;
  logic             beat_rw;
  logic [1:0]       beat_sz;
  logic [3:0]       beat_k;
  logic [31:0]      beat_start;
  logic [31:0]      beat_addr;
  logic [31:0]      offset;
  logic             in_range;
  logic [IDX_W-1:0] idx;
  wire              unused_addr_lsb = ^address[1:0];
`ifdef MEM_BURST_WRAP_EN
  logic [31:0]      wrap_mask;
`endif

  function automatic logic [4:0] words_f(input logic [1:0] sz);
    case (sz)
      2'b00:   return 5'd1;
      2'b01:   return 5'd4;
      2'b10:   return 5'd8;
      default: return 5'd16;
    endcase
  endfunction

  // In IDLE the beat comes straight from the request pins; in BURST from the latched request.
  always_comb begin
    if (state == IDLE) begin
      beat_go    = enable;
      beat_rw    = rw;
      beat_sz    = access_size;
      beat_k     = 4'd0;
      beat_start = {address[31:2], 2'b00};
    end else begin
      beat_go    = 1'b1;
      beat_rw    = rw_q;
      beat_sz    = size_q;
      beat_k     = k_q;
      beat_start = start_q;
    end
    beat_addr = beat_start + {26'd0, beat_k, 2'b00};
`ifdef MEM_BURST_WRAP_EN
    wrap_mask = {25'd0, words_f(beat_sz), 2'b00} - 32'd1;
    beat_addr = (beat_start & ~wrap_mask) | (beat_addr & wrap_mask);
`endif
    // Unsigned subtraction makes addresses below base_addr wrap to huge offsets.
    offset   = beat_addr - base_addr;
    in_range = (offset < memory_depth);
    idx      = offset[IDX_W+1:2];
  end

  // Storage is never reset.
  always_ff @(posedge clock) begin
    if (beat_go && beat_rw && in_range) begin
      mem[idx] <= data_in;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      busy     <= 1'b0;
      data_out <= 32'd0;
      addr_err <= 1'b0;
      cnt      <= 4'd0;
      k_q      <= 4'd0;
      start_q  <= 32'd0;
      size_q   <= 2'b00;
      rw_q     <= 1'b0;
    end else begin
      if (beat_go) begin
        addr_err <= ~in_range;
        if (!beat_rw) begin
          data_out <= in_range ? mem[idx] : 32'd0;
        end
      end else begin
        addr_err <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (enable) begin
            start_q <= beat_start;
            size_q  <= access_size;
            rw_q    <= rw;
            if (access_size != 2'b00) begin
              state <= BURST;
              busy  <= 1'b1;
              cnt   <= 4'(words_f(access_size) - 5'd1);
              k_q   <= 4'd1;
            end
          end
        end
        BURST: begin
          cnt <= cnt - 4'd1;
          k_q <= k_q + 4'd1;
          if (cnt == 4'd1) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: bursts, single access, range errors, wrap order, mid-burst reset.
module tb_mem_responder;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] address;
  logic [31:0] data_in;
  logic [1:0]  access_size;
  logic        rw;
  logic        enable;
  logic        busy;
  logic [31:0] data_out;
  logic        addr_err;

  int n_checks = 0;
  int n_err = 0;
  int bcnt;

  logic [31:0] pre  [4] = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
`ifdef MEM_BURST_WRAP_EN
  logic [31:0] exp8 [4] = '{32'h33333333, 32'h44444444, 32'h11111111, 32'h22222222};
`else
  logic [31:0] exp8 [4] = '{32'h33333333, 32'h44444444, 32'h55555555, 32'h66666666};
  logic [31:0] edge_wd [4] = '{32'hA5A5A5A5, 32'h5A5A5A5A, 32'h77777777, 32'h88888888};
  logic [31:0] edge_rd [4] = '{32'hA5A5A5A5, 32'h5A5A5A5A, 32'h00000000, 32'h00000000};
  logic [31:0] edge_er [4] = '{32'd0, 32'd0, 32'd1, 32'd1};
`endif

  always #5 clock = ~clock;

  mem_responder dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .address    (address),
    .data_in    (data_in),
    .access_size(access_size),
    .rw         (rw),
    .enable     (enable),
    .busy       (busy),
    .data_out   (data_out),
    .addr_err   (addr_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic beat(input logic en, input logic w, input logic [1:0] sz,
                      input logic [31:0] a, input logic [31:0] d);
    enable      = en;
    rw          = w;
    access_size = sz;
    address     = a;
    data_in     = d;
    @(posedge clock);
    #1;
  endtask

  initial begin
    enable = 1'b0; rw = 1'b0; access_size = 2'b00; address = 32'd0; data_in = 32'd0;
    #12;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_data_out", data_out, 32'd0);
    chk("rst_addr_err", {31'd0, addr_err}, 32'd0);
    reset_n = 1'b1;

    // 4-word write burst preloading the first block
    beat(1'b1, 1'b1, 2'b01, 32'h80020000, pre[0]);
    chk("wr4_busy_first", {31'd0, busy}, 32'd1);
    chk("wr4_data_out_hold", data_out, 32'd0);
    for (int k = 1; k < 4; k++) beat(1'b0, 1'b0, 2'b00, 32'd0, pre[k]);
    chk("wr4_busy_end", {31'd0, busy}, 32'd0);

    bcnt = 0;
    for (int k = 0; k < 4; k++) begin
      beat(k == 0, 1'b0, 2'b01, 32'h80020000, 32'd0);
      chk($sformatf("rd4_word%0d", k), data_out, pre[k]);
      if (busy) bcnt++;
    end
    chk("rd4_busy_cycles", bcnt, 32'd3);

    // single write then single read; low address bits are ignored
    beat(1'b1, 1'b1, 2'b00, 32'h80020040, 32'hDEADBEEF);
    chk("sw_busy", {31'd0, busy}, 32'd0);
    chk("sw_data_out_hold", data_out, 32'h44444444);
    beat(1'b1, 1'b0, 2'b00, 32'h80020042, 32'd0);
    chk("sr_data", data_out, 32'hDEADBEEF);
    chk("sr_busy", {31'd0, busy}, 32'd0);
    chk("sr_addr_err", {31'd0, addr_err}, 32'd0);
    beat(1'b0, 1'b0, 2'b00, 32'd0, 32'd0);
    chk("idle_addr_err", {31'd0, addr_err}, 32'd0);
    chk("idle_data_hold", data_out, 32'hDEADBEEF);

    // below base address
    beat(1'b1, 1'b0, 2'b00, 32'h8001FFFC, 32'd0);
    chk("below_data", data_out, 32'd0);
    chk("below_err", {31'd0, addr_err}, 32'd1);

    beat(1'b1, 1'b1, 2'b00, 32'h80020010, 32'h55555555);
    chk("sw2_err", {31'd0, addr_err}, 32'd0);
    beat(1'b1, 1'b1, 2'b00, 32'h80020014, 32'h66666666);

    // burst starting mid-block: wrap order or linear order depending on build
    for (int k = 0; k < 4; k++) begin
      beat(k == 0, 1'b0, 2'b01, 32'h80020008, 32'd0);
      chk($sformatf("rd8_word%0d", k), data_out, exp8[k]);
    end

`ifndef MEM_BURST_WRAP_EN
    // linear burst running off the top of the mapped range
    for (int k = 0; k < 4; k++) begin
      beat(k == 0, 1'b1, 2'b01, 32'h8011FFF8, edge_wd[k]);
      chk($sformatf("edge_wr_err%0d", k), {31'd0, addr_err}, edge_er[k]);
    end
    for (int k = 0; k < 4; k++) begin
      beat(k == 0, 1'b0, 2'b01, 32'h8011FFF8, 32'd0);
      chk($sformatf("edge_rd%0d", k), data_out, edge_rd[k]);
      chk($sformatf("edge_rd_err%0d", k), {31'd0, addr_err}, edge_er[k]);
    end
    chk("edge_busy_end", {31'd0, busy}, 32'd0);
`endif

    // request changes during a burst are ignored; new request served after busy falls
    beat(1'b1, 1'b0, 2'b01, 32'h80020000, 32'd0);
    chk("ign_beat0", data_out, pre[0]);
    beat(1'b1, 1'b1, 2'b00, 32'h80020040, 32'd0);
    chk("ign_beat1", data_out, pre[1]);
    beat(1'b1, 1'b1, 2'b00, 32'h80020040, 32'd0);
    chk("ign_beat2", data_out, pre[2]);
    beat(1'b1, 1'b0, 2'b00, 32'h80020040, 32'd0);
    chk("ign_beat3", data_out, pre[3]);
    chk("ign_busy_fall", {31'd0, busy}, 32'd0);
    beat(1'b1, 1'b0, 2'b00, 32'h80020040, 32'd0);
    chk("ign_new_req", data_out, 32'hDEADBEEF);

    // preload 16 words, then abort a 16-word overwrite after beat 2
    for (int k = 0; k < 16; k++) beat(k == 0, 1'b1, 2'b11, 32'h80020100, 32'hB0000000 + k);
    chk("pre16_busy_end", {31'd0, busy}, 32'd0);
    for (int k = 0; k < 3; k++) beat(k == 0, 1'b1, 2'b11, 32'h80020100, 32'hC0000000 + k);
    chk("abort_busy_before", {31'd0, busy}, 32'd1);
    #1 reset_n = 1'b0;
    #1;
    chk("abort_busy_async", {31'd0, busy}, 32'd0);
    chk("abort_data_out_async", data_out, 32'd0);
    reset_n = 1'b1;
    for (int k = 0; k < 16; k++) begin
      beat(k == 0, 1'b0, 2'b11, 32'h80020100, 32'd0);
      chk($sformatf("abort_rd%0d", k), data_out,
          (k < 3) ? (32'hC0000000 + k) : (32'hB0000000 + k));
    end
    chk("abort_rd_busy_end", {31'd0, busy}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
